// File: rtl/arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_pkg: shared types and the round-robin search helper for the      |
// | stream arbiter.                                                      |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam int MAX_CH   = 32;
  localparam int MAX_CH_W = $clog2(MAX_CH);

  // Offsets are scanned from the far end so the closest set bit to ptr wins last.
  function automatic int rr_next(input logic [MAX_CH-1:0] req, input int ptr, input int n);
    int result;
    int idx;
    result = ptr;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (req[idx[MAX_CH_W-1:0]]) result = idx;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_picker: combinational round-robin pick of the first requesting    |
// | channel at or after ptr, wrapping around.                            |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module rr_picker
  import arb_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int SRC_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] gnt_idx,
  output logic             any_req
);

  logic [MAX_CH-1:0] w_req_ext;

  assign w_req_ext = MAX_CH'(req);
  assign gnt_idx   = SRC_W'(rr_next(w_req_ext, int'(ptr), N_CH));
  assign any_req   = |req;

endmodule
`default_nettype wire

// File: rtl/rr_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_stream_arbiter: N-channel round-robin burst arbiter feeding the   |
// | shared input FIFO write port, with back-pressure and source tag.     |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module rr_stream_arbiter
  import arb_pkg::*;
#(
  parameter int DW        = 32,
  parameter int N_CH      = 4,
  parameter int MAX_BURST = 16,
  localparam int SRC_W    = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*N_CH-1:0]    ch_mode,
  input  logic [DW*N_CH-1:0]   ch_data,
  input  logic [8*N_CH-1:0]    ch_proc_val,
  input  logic [N_CH-1:0]      ch_data_valid,
  input  logic [N_CH-1:0]      ch_last,
  output logic [N_CH-1:0]      ch_ready,
  input  logic                 fifo_full,
  input  logic                 mstr_cmplt,
  output logic [1:0]           slvx_mode,
  output logic [DW-1:0]        slvx_data,
  output logic [7:0]           slvx_proc_val,
  output logic                 slvx_data_valid,
  output logic [SRC_W-1:0]     data_source
);

  localparam int               CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] C_MAX     = CNT_W'(MAX_BURST);
  localparam logic [SRC_W-1:0] C_LAST_CH = SRC_W'(N_CH - 1);

  arb_state_t       r_state;
  logic [SRC_W-1:0] r_rr_ptr;
  logic [SRC_W-1:0] r_gnt_idx;
  logic [CNT_W-1:0] r_beat_cnt;

  logic [N_CH-1:0]  w_req;
  logic [SRC_W-1:0] w_pick;
  logic             w_any_req;
  logic             w_granted;
  logic             w_stall;
  logic             w_accept;
  logic             w_release;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [SRC_W-1:0] w_ptr_nxt;
  logic [DW-1:0]    w_sel_data;
  logic [7:0]       w_sel_pv;
  logic [1:0]       w_sel_mode;
  logic             w_sel_valid;
  logic             w_sel_last;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_req
      assign w_req[i] = (ch_mode[2*i +: 2] != MODE_NONE);
    end
  endgenerate

  rr_picker #(.N_CH(N_CH)) u_picker (
    .req     (w_req),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_pick),
    .any_req (w_any_req)
  );

  always_comb begin
    w_sel_data  = '0;
    w_sel_pv    = '0;
    w_sel_mode  = MODE_NONE;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_gnt_idx == SRC_W'(i)) begin
        w_sel_data  = ch_data[i*DW +: DW];
        w_sel_pv    = ch_proc_val[i*8 +: 8];
        w_sel_mode  = ch_mode[2*i +: 2];
        w_sel_valid = ch_data_valid[i];
        w_sel_last  = ch_last[i];
      end
    end
  end

  assign w_granted = (r_state == GRANT);
  assign w_stall   = fifo_full | mstr_cmplt;
  assign w_accept  = w_granted & ~w_stall & w_sel_valid;
  assign w_cnt_nxt = r_beat_cnt + CNT_W'(1);
  assign w_ptr_nxt = (r_gnt_idx == C_LAST_CH) ? '0 : r_gnt_idx + SRC_W'(1);

  // A stalled grant never releases, even if the channel drops its request.
  assign w_release = (w_accept & (w_sel_last | (w_cnt_nxt == C_MAX)))
                   | (w_granted & ~w_stall & ~w_accept & (w_sel_mode == MODE_NONE));

  always_comb begin
    ch_ready = '0;
    if (w_granted && !w_stall) ch_ready[r_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_rr_ptr        <= '0;
      r_gnt_idx       <= '0;
      r_beat_cnt      <= '0;
      slvx_mode       <= MODE_NONE;
      slvx_data       <= '0;
      slvx_proc_val   <= '0;
      slvx_data_valid <= 1'b0;
      data_source     <= '0;
    end else begin
      slvx_data_valid <= w_accept;
      if (w_accept) begin
        slvx_data     <= w_sel_data;
        slvx_proc_val <= w_sel_pv;
        slvx_mode     <= w_sel_mode;
        data_source   <= r_gnt_idx;
      end
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt_idx  <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (w_accept) r_beat_cnt <= w_cnt_nxt;
          if (w_release) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_ptr_nxt;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

Parametrised N-channel round-robin arbiter that merges processing-slave pixel streams into the single write port of the accelerator's shared input FIFO. It generalises the two-slave arbiter to N_CH channels with configurable data width, burst locking (grant held until `last` or MAX_BURST beats), FIFO back-pressure, master-complete pause and a source-ID tag on every beat. It sits between the slave-side processing engines and the FIFO write side.

## Interface
- DW, 32, data width per channel
- N_CH, 4, number of requesting channels (≥2)
- MAX_BURST, 16, maximum beats per grant (≥1)
- SRC_W, $clog2(N_CH), width of the source tag (derived, not overridden)

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ch_mode  in  2*N_CH  per-channel mode; 2'b00 = no request, any nonzero value = request
- ch_data  in  DW*N_CH  channel i at [i*DW +: DW]
- ch_proc_val  in  8*N_CH  per-channel processing value
- ch_data_valid  in  N_CH  beat valid
- ch_last  in  N_CH  final beat of the channel's burst
- ch_ready  out  N_CH  beat accepted when ch_data_valid[i] & ch_ready[i]
- fifo_full  in  1  FIFO has ≤1 free entry (almost-full semantics)
- mstr_cmplt  in  1  master complete; pauses all acceptance
- slvx_mode  out  2  mode of the written beat
- slvx_data  out  DW  written data
- slvx_proc_val  out  8  written processing value
- slvx_data_valid  out  1  one-cycle FIFO write strobe
- data_source  out  SRC_W  index of the channel that produced the beat

## Operation
- FSM states: IDLE, GRANT.
- IDLE: request vector req[i] = (ch_mode[i] != 0). If any bit is set, pick the first set bit at or after rr_ptr (wrapping), register it as gnt_idx, clear beat_cnt and go to GRANT. If no bit is set, stay in IDLE. No ch_ready is asserted in IDLE.
- GRANT: ch_ready[gnt_idx] = ~fifo_full & ~mstr_cmplt. ch_ready is combinational from state, gnt_idx, fifo_full and mstr_cmplt. All other ready bits are 0.
- Accepted beat: register data, proc_val and mode of gnt_idx, data_source = gnt_idx, slvx_data_valid = 1, beat_cnt++.
- Release (→ IDLE, rr_ptr = gnt_idx+1 mod N_CH) on any of:
  - accepted beat with ch_last[gnt_idx];
  - accepted beat with beat_cnt+1 == MAX_BURST;
  - ch_mode[gnt_idx] == 0 with no beat accepted this cycle.
- mstr_cmplt or fifo_full while in GRANT: grant, beat_cnt and rr_ptr are held; nothing is accepted; no release.
- A channel that asserts ch_data_valid with mode 0 is never granted; its valid is ignored.

## Timing
- Reset values: state IDLE, rr_ptr 0, gnt_idx 0, beat_cnt 0. All outputs 0, including ch_ready and slvx_*.
- Request to first ready: 1 cycle (IDLE→GRANT). Every grant boundary costs exactly one IDLE cycle.
- Beat latency: acceptance at edge k → slvx_* valid during cycle k+1. Throughput is 1 beat/clk while in GRANT and unstalled.
- slvx_data_valid is high only in the cycle after an acceptance. slvx_data/proc_val/mode/data_source hold their last value otherwise.
- Almost-full rule: because the write is one cycle late, fifo_full must assert with one entry still free. The block never issues more than one write after fifo_full rises.
- Simultaneous last and MAX_BURST: a single release.
- Reset mid-burst: everything clears immediately. The burst restarts from channel 0 priority after reset.
- beat_cnt width: $clog2(MAX_BURST+1). It never exceeds MAX_BURST.

## Structure
- Package arb_pkg contains:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - localparam MODE_NONE = 2'b00;
  - function rr_next(req, ptr), returning the index of the first set bit at or after ptr, wrapping.
- Sub-module rr_picker (combinational, parameter N_CH): inputs req and ptr; outputs gnt_idx and any_req. The arbiter instantiates it once.

## Test plan
- Single channel 2 requests, 3 beats (D0, D1, D2 with last on D2) → ready 1 cycle after the request; slvx_data_valid on 3 consecutive cycles; data_source = 2; IDLE afterwards.
- All 4 channels request continuously with 2-beat bursts → grant order 0, 1, 2, 3, 0; one idle cycle between bursts; no channel starved.
- Channel 1 streams 20 beats with no last, MAX_BURST = 16 → release after 16 beats; channel 2 (requesting) is served next; channel 1 resumes later.
- fifo_full rises mid-burst for 3 cycles → ch_ready is 0 for exactly those cycles; exactly 0 or 1 writes after the rise (the beat already in flight); the burst continues without loss or duplication.
- mstr_cmplt pulses for 2 cycles, then rst asserted mid-burst → no acceptance during the pause with the grant retained; on rst all outputs are 0 asynchronously; the first grant after reset goes to the lowest requesting index.
